score_keeper: RTL and testbench
===============================

# score_keeper

Per-user high-score store that consumes the login result of the access controller (access-granted flag plus 3-bit user address) and the end-of-round score from the game controller. On login it fetches the logged-in user's high score from an internal RAM for display. At each game end it compares the round score against that high score and writes back a new record. It sits between the access controller, the game controller and the 7-segment decoder path.

## Interface
- SCORE_W, 8: score width in bits, unsigned.
- N_USERS, 8: RAM depth; addresses 0..N_USERS-1. User addresses 0..5 are assigned; 6 and 7 are legal but unused.
- RD_LAT, 2: RAM read latency in clocks.
- clk  in  1  system clock.
- rst  in  1  reset; **synchronous, active-low**.
- valid_in  in  1  access granted; level, high while a user is logged in.
- user_ID  in  3  RAM address of the logged-in user; sampled only on login.
- game_score  in  SCORE_W  final score of the round; valid when game_done=1.
- game_done  in  1  one-cycle pulse at the end of a round.
- high_score  out  SCORE_W  current user's high score; 0 when nobody is logged in.
- new_record  out  1  the last round set a new high score.
- busy  out  1  block is clearing, fetching or writing; game_done is ignored while busy.

## Operation
- States: CLEAR, IDLE, FETCH, SHOW, WRITE.
- **Reset** (rst=0 sampled): all of the following take effect at that edge, regardless of current state, including a reset mid-FETCH or mid-WRITE.
  - State becomes CLEAR; clear counter = 0.
  - high_score=0, new_record=0, busy=1.
- **CLEAR**: writes 0 to one RAM address per clock, 0..N_USERS-1 (8 clocks). After the last write the state becomes IDLE. valid_in is ignored during CLEAR.
- **IDLE**: busy=0, high_score=0, new_record=0.
  - valid_in=1 sampled: latch user_ID into the address register and go to FETCH.
- **FETCH**: busy=1; waits RD_LAT clocks.
  - On completion, high_score takes the RAM read data, new_record=0, and the state becomes SHOW.
  - valid_in=0 sampled during FETCH aborts to IDLE; the read is discarded.
- **SHOW**: busy=0.
  - valid_in=0 sampled: go to IDLE (logout); this takes priority over game_done in the same cycle.
  - game_done=1 and game_score > high_score: high_score <= game_score, new_record <= 1, go to WRITE.
  - game_done=1 and game_score <= high_score: new_record <= 0; stay in SHOW. A tie is not a record.
- **WRITE**: busy=1 for exactly one clock.
  - RAM write enable=1, address = latched user address, data = high_score.
  - Always returns to SHOW. If valid_in=0 is sampled here, the write still completes and the next state is IDLE.
- user_ID changes while in SHOW have no effect; the latched address is used until logout.
- game_done in any state other than SHOW is dropped and is not queued.
- Comparison is unsigned, full SCORE_W. No saturation is needed because the stored value is a copy of the input.

## Timing
- Reset release to IDLE: N_USERS clocks in CLEAR. busy=1 throughout.
- Login latency: valid_in first sampled high at edge T gives FETCH at T, SHOW with a valid high_score at T+RD_LAT+1.
- Record update: game_done sampled at edge T updates high_score/new_record at T, asserts the RAM write during the cycle after T, and returns to SHOW at T+1.
- Write-then-read: a new login that reaches FETCH at least 1 clock after a WRITE must read the new value. The RAM is read-after-write safe across cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - state encodings (5 states, 3 bits);
  - SCORE_W, N_USERS and RD_LAT defaults;
  - user address constants 0..5, shared with the access controller.
- Sub-module **high_score_ram**: single-port, N_USERS x SCORE_W, synchronous write, RD_LAT-registered read, no reset on contents. Clearing is done by the CLEAR sweep.
- The FSM, latched address register, clear counter and FETCH wait counter live in score_keeper.

## Test plan
- **Reset sweep**: rst=0 for 1 clk, then 1.
  - busy=1 for exactly 8 clks, then IDLE.
  - Login as each of users 0..5 returns high_score=0.
- **First record**: login user 2, game_done with score 37.
  - high_score=37 and new_record=1 one edge later; busy=1 for 1 clk.
  - Logout, re-login user 2: high_score=37 at T+3.
- **Non-record and tie**: user 2 holds 37.
  - Score 20 gives high_score=37, new_record=0, no write.
  - Score 37 gives the same result.
  - Score 38 gives high_score=38, new_record=1.
- **Isolation**: user 0 scores 90, logout, user 5 logs in.
  - User 5 shows high_score=0.
  - User 0 re-login shows 90.
  - User 0 scoring 255 (max) is stored and read back as 255.
- **Simultaneous and abort**:
  - valid_in falls in the same cycle as game_done in SHOW: IDLE, no write.
  - valid_in falls during FETCH: IDLE, high_score stays 0.
  - game_done during FETCH is dropped.
- **Reset mid-operation**: assert rst during WRITE.
  - CLEAR follows; all entries read back 0 afterwards.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared definitions for the score keeper and its neighbours.
// Holds widths, RAM depth/latency, FSM state encodings and user addresses.
package score_keeper_pkg;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned N_USERS = 8;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned ADDR_W  = $clog2(N_USERS);

  // FSM encodings (3 bits, five states)
  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  // Assigned user addresses, shared with the access controller
  localparam logic [ADDR_W-1:0] USER_0 = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] USER_1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] USER_2 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] USER_3 = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] USER_4 = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] USER_5 = ADDR_W'(5);

endpackage

// File: rtl/score_keeper_if.sv
// Bundle between access/game controllers (master) and the score keeper (slave).
// Signals: valid_in, user_ID, game_score, game_done toward the keeper;
//          high_score, new_record, busy back to the display path.
interface score_keeper_if;

  logic                                  valid_in;
  logic [score_keeper_pkg::ADDR_W-1:0]   user_ID;
  logic [score_keeper_pkg::SCORE_W-1:0]  game_score;
  logic                                  game_done;
  logic [score_keeper_pkg::SCORE_W-1:0]  high_score;
  logic                                  new_record;
  logic                                  busy;

  modport master (
    output valid_in, user_ID, game_score, game_done,
    input  high_score, new_record, busy
  );

  modport slave (
    input  valid_in, user_ID, game_score, game_done,
    output high_score, new_record, busy
  );

endinterface

// File: rtl/score_keeper_high_score_ram.sv
// Single-port N_USERS x SCORE_W high-score RAM.
// Ports: clk; we_i/addr_i/wdata_i synchronous write; rdata_o is the read of
// addr_i delayed by RD_LAT registers. Contents have no reset.
module score_keeper_high_score_ram
  import score_keeper_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [SCORE_W-1:0] wdata_i,
  output logic [SCORE_W-1:0] rdata_o
);

  logic [SCORE_W-1:0] mem_q     [N_USERS];
  logic [SCORE_W-1:0] rd_pipe_q [RD_LAT];

  // Storage write plus read pipeline; a read in the write cycle sees old data
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rd_pipe_q[0] <= mem_q[addr_i];
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign rdata_o = rd_pipe_q[RD_LAT-1];

endmodule

// File: rtl/score_keeper.sv
// Per-user high-score store: clears the RAM after reset, fetches the user's
// record on login, and writes back a new record when a round beats it.
// Ports: clk, rst (sync, active-low); sk (slave side of score_keeper_if).
module score_keeper
  import score_keeper_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  score_keeper_if.slave sk
);

  localparam int unsigned WAIT_W = $clog2(RD_LAT + 1);

  logic [2:0]         state_q,      state_d;
  logic [ADDR_W-1:0]  clr_cnt_q,    clr_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q,   wait_cnt_d;
  logic [ADDR_W-1:0]  addr_q,       addr_d;
  logic [SCORE_W-1:0] high_score_q, high_score_d;
  logic               new_record_q, new_record_d;
  logic               busy_q,       busy_d;

  logic               ram_we_c;
  logic [ADDR_W-1:0]  ram_addr_c;
  logic [SCORE_W-1:0] ram_wdata_c;
  logic [SCORE_W-1:0] ram_rdata;

  score_keeper_high_score_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .addr_i  (ram_addr_c),
    .wdata_i (ram_wdata_c),
    .rdata_o (ram_rdata)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      high_score_q <= '0;
      new_record_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      high_score_q <= high_score_d;
      new_record_q <= new_record_d;
      busy_q       <= busy_d;
    end
  end

  // Next state, next outputs and RAM controls
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    high_score_d = high_score_q;
    new_record_d = new_record_q;
    busy_d       = busy_q;
    ram_we_c     = 1'b0;
    ram_addr_c   = addr_q;
    ram_wdata_c  = high_score_q;

    case (state_q)
      ST_CLEAR: begin
        ram_we_c     = 1'b1;
        ram_addr_c   = clr_cnt_q;
        ram_wdata_c  = '0;
        high_score_d = '0;
        new_record_d = 1'b0;
        busy_d       = 1'b1;
        if (clr_cnt_q == ADDR_W'(N_USERS - 1)) begin
          clr_cnt_d = '0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end

      ST_IDLE: begin
        high_score_d = '0;
        new_record_d = 1'b0;
        busy_d       = 1'b0;
        if (sk.valid_in) begin
          addr_d     = sk.user_ID;
          wait_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      // Abort wins over completion; data is taken once RD_LAT cycles elapsed
      ST_FETCH: begin
        if (!sk.valid_in) begin
          high_score_d = '0;
          new_record_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end else if (wait_cnt_q == WAIT_W'(RD_LAT)) begin
          high_score_d = ram_rdata;
          new_record_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = ST_SHOW;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      // Logout takes priority over a round ending in the same cycle
      ST_SHOW: begin
        if (!sk.valid_in) begin
          high_score_d = '0;
          new_record_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end else if (sk.game_done) begin
          if (sk.game_score > high_score_q) begin
            high_score_d = sk.game_score;
            new_record_d = 1'b1;
            busy_d       = 1'b1;
            state_d      = ST_WRITE;
          end else begin
            new_record_d = 1'b0;
          end
        end
      end

      // Write always commits, even if the user logs out this cycle
      ST_WRITE: begin
        ram_we_c = 1'b1;
        busy_d   = 1'b0;
        if (!sk.valid_in) begin
          high_score_d = '0;
          new_record_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_SHOW;
        end
      end

      default: begin
        clr_cnt_d    = '0;
        high_score_d = '0;
        new_record_d = 1'b0;
        busy_d       = 1'b1;
        state_d      = ST_CLEAR;
      end
    endcase
  end

  assign sk.high_score = high_score_q;
  assign sk.new_record = new_record_q;
  assign sk.busy       = busy_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus queues expected
// {busy, new_record, high_score} per clock edge, a monitor compares them.
module tb_score_keeper;
  import score_keeper_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_keeper_if sk_if ();

  score_keeper dut (
    .clk (clk),
    .rst (rst),
    .sk  (sk_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int                 q_cyc  [$];
  string              q_name [$];
  logic [SCORE_W+1:0] q_val  [$];

  function automatic void expect_at(int k, string nm, logic [SCORE_W-1:0] hs,
                                    logic nr, logic bz);
    q_cyc.push_back(k);
    q_name.push_back(nm);
    q_val.push_back({bz, nr, hs});
  endfunction

  // Monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    logic [SCORE_W+1:0] act;
    logic [SCORE_W+1:0] req;
    act = {sk_if.busy, sk_if.new_record, sk_if.high_score};
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      checks = checks + 1;
      req = q_val[0];
      if (q_cyc[0] < cyc) begin
        errors = errors + 1;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d",
                 q_name[0], q_cyc[0], cyc);
      end else if (act !== req) begin
        errors = errors + 1;
        $display("FAIL %s @%0d: got busy=%b new_record=%b high_score=%0d, required busy=%b new_record=%b high_score=%0d",
                 q_name[0], cyc, act[SCORE_W+1], act[SCORE_W], act[SCORE_W-1:0],
                 req[SCORE_W+1], req[SCORE_W], req[SCORE_W-1:0]);
      end
      void'(q_cyc.pop_front());
      void'(q_name.pop_front());
      void'(q_val.pop_front());
    end
  end

  // All tasks start and end on a negedge
  task automatic login(input logic [ADDR_W-1:0] u, input logic [SCORE_W-1:0] hs,
                       input string nm);
    int c;
    c = cyc;
    sk_if.valid_in = 1'b1;
    sk_if.user_ID  = u;
    for (int d = 1; d <= 3; d++) expect_at(c + d, {nm, "_fetch"}, '0, 1'b0, 1'b1);
    expect_at(c + 4, {nm, "_show"}, hs, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic logout(input string nm);
    sk_if.valid_in = 1'b0;
    expect_at(cyc + 1, nm, '0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic play(input logic [SCORE_W-1:0] score, input logic rec,
                      input logic [SCORE_W-1:0] hs, input string nm);
    int c;
    c = cyc;
    sk_if.game_done  = 1'b1;
    sk_if.game_score = score;
    if (rec) begin
      expect_at(c + 1, {nm, "_write"}, score, 1'b1, 1'b1);
      expect_at(c + 2, {nm, "_show"},  score, 1'b1, 1'b0);
    end else begin
      expect_at(c + 1, {nm, "_nowr"}, hs, 1'b0, 1'b0);
      expect_at(c + 2, {nm, "_hold"}, hs, 1'b0, 1'b0);
    end
    @(negedge clk);
    sk_if.game_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [ADDR_W-1:0] users [6];
    int c;
    users = '{USER_0, USER_1, USER_2, USER_3, USER_4, USER_5};
    rst = 1'b0;
    sk_if.valid_in   = 1'b0;
    sk_if.user_ID    = '0;
    sk_if.game_score = '0;
    sk_if.game_done  = 1'b0;

    // Reset sweep: busy for 8 clocks, then IDLE
    for (int k = 1; k <= 8; k++) expect_at(k, "reset_clear", '0, 1'b0, 1'b1);
    expect_at(9, "reset_idle", '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    for (int u = 0; u < 6; u++) begin
      login(users[u], 8'd0, $sformatf("init_u%0d", u));
      logout($sformatf("init_out_u%0d", u));
    end

    // First record
    login(USER_2, 8'd0, "u2_first");
    play(8'd37, 1'b1, 8'd37, "u2_rec37");
    logout("u2_out1");
    login(USER_2, 8'd37, "u2_relog37");

    // Non-record and tie leave the store untouched
    play(8'd20, 1'b0, 8'd37, "u2_lower");
    play(8'd37, 1'b0, 8'd37, "u2_tie37");
    logout("u2_out2");
    login(USER_2, 8'd37, "u2_relog_norec");
    play(8'd38, 1'b1, 8'd38, "u2_rec38");
    play(8'd38, 1'b0, 8'd38, "u2_tie38");
    logout("u2_out3");

    // Isolation between users, max score
    login(USER_0, 8'd0, "u0_first");
    play(8'd90, 1'b1, 8'd90, "u0_rec90");
    logout("u0_out1");
    login(USER_5, 8'd0, "u5_iso");
    logout("u5_out");
    login(USER_0, 8'd90, "u0_relog90");
    play(8'd255, 1'b1, 8'd255, "u0_rec255");
    logout("u0_out2");
    login(USER_0, 8'd255, "u0_relog255");
    logout("u0_out3");

    // Logout and game_done together: logout wins, no write
    login(USER_3, 8'd0, "u3_first");
    c = cyc;
    sk_if.valid_in   = 1'b0;
    sk_if.game_done  = 1'b1;
    sk_if.game_score = 8'd50;
    expect_at(c + 1, "simul_idle", '0, 1'b0, 1'b0);
    expect_at(c + 2, "simul_hold", '0, 1'b0, 1'b0);
    @(negedge clk);
    sk_if.game_done = 1'b0;
    @(negedge clk);

    // Abort during FETCH of a non-zero record
    c = cyc;
    sk_if.valid_in = 1'b1;
    sk_if.user_ID  = USER_0;
    expect_at(c + 1, "abort_fetch", '0, 1'b0, 1'b1);
    expect_at(c + 2, "abort_idle",  '0, 1'b0, 1'b0);
    expect_at(c + 3, "abort_hold",  '0, 1'b0, 1'b0);
    @(negedge clk);
    sk_if.valid_in = 1'b0;
    repeat (2) @(negedge clk);

    // game_done during FETCH is dropped; also confirms user 3 kept 0
    c = cyc;
    sk_if.valid_in = 1'b1;
    sk_if.user_ID  = USER_3;
    for (int d = 1; d <= 3; d++) expect_at(c + d, "drop_fetch", '0, 1'b0, 1'b1);
    expect_at(c + 4, "drop_show", '0, 1'b0, 1'b0);
    expect_at(c + 5, "drop_hold", '0, 1'b0, 1'b0);
    @(negedge clk);
    sk_if.game_done  = 1'b1;
    sk_if.game_score = 8'd99;
    @(negedge clk);
    sk_if.game_done = 1'b0;
    repeat (3) @(negedge clk);
    logout("drop_out");

    // Reset during WRITE, then every entry reads back 0
    login(USER_1, 8'd0, "u1_first");
    c = cyc;
    sk_if.game_done  = 1'b1;
    sk_if.game_score = 8'd77;
    expect_at(c + 1, "mid_write", 8'd77, 1'b1, 1'b1);
    @(negedge clk);
    sk_if.game_done = 1'b0;
    sk_if.valid_in  = 1'b0;
    rst = 1'b0;
    for (int d = 2; d <= 9; d++) expect_at(c + d, "mid_clear", '0, 1'b0, 1'b1);
    expect_at(c + 10, "mid_idle", '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    for (int u = 0; u < int'(N_USERS); u++) begin
      login(ADDR_W'(u), 8'd0, $sformatf("post_u%0d", u));
      logout($sformatf("post_out_u%0d", u));
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && q_cyc.size() > 0; i++) @(negedge clk);
    checks = checks + 1;
    if (q_cyc.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", q_cyc.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
